hist_accum: RTL and testbench
=============================

# hist_accum

Pass-1 histogram accumulator for the equalization pipeline. It counts 8-bit pixel occurrences from an AXI-Stream frame into a 256-bin RAM and latches the frame pixel count. When the frame ends, it streams bins 0..255 in order to the downstream CDF/LUT stage. That stage consumes `hist_out`, `hist_addr` and `t_total` and asserts its write strobe on each `hist_valid && readout_ready` beat.

## Interface
- `CNT_W`, 32: width of each bin and of `t_total`.
- `clk`  in  1: clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `s_axis_tdata`  in  8: pixel value.
- `s_axis_tvalid`  in  1: pixel valid.
- `s_axis_tlast`  in  1: last pixel of frame.
- `s_axis_tready`  out  1: high only in ACCUM.
- `readout_ready`  in  1: downstream accepts the current bin.
- `hist_valid`  out  1: `hist_out`/`hist_addr` valid.
- `hist_addr`  out  8: bin index k.
- `hist_out`  out  CNT_W: count of bin k.
- `t_total`  out  CNT_W: beats accepted in the last completed frame.
- `readout_done`  out  1: one-cycle pulse after bin 255 is accepted.
- `busy`  out  1: high in every state except ACCUM.

## Operation
- States: CLEAR, ACCUM, DRAIN, READ.
- **Reset** enters CLEAR with the clear index at 0. RAM contents are not reset.
- **CLEAR:** writes 0 to bins 0..255, one bin per cycle (256 cycles), then goes to ACCUM.
- **ACCUM:** `s_axis_tready` = 1. On each handshake, the bin at index `tdata` is incremented and the frame counter is incremented.
  - Read-modify-write runs in a 2-stage pipeline with forwarding.
  - Counts must be exact for any sequence, including runs of identical pixels and A,B,A patterns at full rate.
- **Saturation:** a bin at 2^CNT_W−1 holds its value; it does not wrap.
- **End of frame:** a handshake with `tlast` = 1 moves the block to DRAIN. In the same cycle:
  - `t_total` ← frame counter + 1.
  - The frame counter ← 0.
- **DRAIN:** waits until the pipeline is empty (2 cycles), prefetches bin 0, then goes to READ.
- **READ:** `hist_valid` = 1 and `hist_out` = bin[`hist_addr`].
  - On `hist_valid && readout_ready`, `hist_addr` increments and the next bin is presented on the following cycle with no bubble.
  - With `readout_ready` low, all outputs hold stable.
- **After the handshake at `hist_addr` = 255:**
  - `hist_valid` ← 0.
  - `readout_done` pulses.
  - The next state is set by the macro (see Configuration).
- **`t_total`** is held stable from the DRAIN entry until the next `tlast` handshake. This lets the downstream stage sample it during READ.

## Timing
- **Reset values:** `s_axis_tready` 0, `hist_valid` 0, `hist_addr` 0, `hist_out` 0, `t_total` 0, `readout_done` 0, `busy` 1.
- **After reset release:** `s_axis_tready` rises on cycle 257.
- **ACCUM throughput:** 1 pixel per cycle. Backpressure occurs only outside ACCUM.
- **`tlast` handshake to first `hist_valid`:** 3 cycles.
- **READ duration:** 256 cycles minimum when `readout_ready` is held high.
- **Reset mid-frame or mid-readout:**
  - All state is abandoned, and outputs return to their reset values next cycle.
  - CLEAR restarts at bin 0.
  - `t_total` = 0.
- **`tvalid` outside ACCUM:** ignored; no handshake occurs.
- **Single-beat frame** (first beat carries `tlast`): `t_total` = 1 and exactly one bin = 1.

## Configuration
- **`HIST_CLEAR_ON_READ_EN` defined:**
  - During READ, each bin is written to 0 on its handshake, using the RAM's read-first port.
  - After `readout_done`, the block goes straight to ACCUM. `s_axis_tready` = 1 the cycle after the `readout_done` pulse.
- **`HIST_CLEAR_ON_READ_EN` undefined:**
  - Bins are untouched during READ.
  - After `readout_done`, the block goes to CLEAR (256 cycles), then to ACCUM.

## Test plan
- **Post-reset clear:** reset, then wait → `s_axis_tready` rises on cycle 257. A 4-pixel frame {7,7,7,7} with `readout_ready` = 1 → bin 7 = 4, all other bins 0, `t_total` = 4.
- **Forwarding hazards:** a full-rate 1000-beat frame alternating {3,3,5,3,5,5,...} plus a 300-beat run of 200 → bins match a software model exactly.
- **Readout backpressure:** toggle `readout_ready` pseudo-randomly → the output stream is exactly 256 beats, `hist_addr` runs 0..255 in order, values are stable while stalled, and `readout_done` pulses once.
- **Back-to-back frames:** frame 1 = 64 beats of 0, frame 2 = 16 beats of 255 → the frame-2 readout shows bin 0 = 0, bin 255 = 16, `t_total` = 16. Also check the first-ready cycle after readout in both macro builds.
- **Reset mid-ACCUM:** assert reset after 10 beats of value 9, then send 2 beats of value 1 → readout shows bin 9 = 0, bin 1 = 2, `t_total` = 2.
- **Saturation:** run with `CNT_W` = 4 and a 20-beat frame of value 12 → bin 12 = 15, `t_total` = 15.

Source files
------------

// File: rtl/hist_accum.sv
// Pass-1 histogram accumulator: clears a 256-bin RAM, counts one frame of pixels, then streams the bins out.
// Optional build macro HIST_CLEAR_ON_READ_EN zeroes each bin as it is read and skips the CLEAR pass.
module hist_accum #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  input  logic             readout_ready,
  output logic             hist_valid,
  output logic [7:0]       hist_addr,
  output logic [CNT_W-1:0] hist_out,
  output logic [CNT_W-1:0] t_total,
  output logic             readout_done,
  output logic             busy
);

  typedef enum logic [1:0] {CLEAR = 2'd0, ACCUM = 2'd1, DRAIN = 2'd2, READ = 2'd3} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] mem_r [0:255];
  logic [7:0]       clr_idx_r;
  logic [1:0]       drain_cnt_r;
  logic [CNT_W-1:0] frame_cnt_r;
  logic [7:0]       a1_r, a2_r;
  logic             v1_r, v2_r;
  logic [CNT_W-1:0] d2_r, rd_data_r;
  logic             tready_r, hist_valid_r, done_r, busy_r;
  logic [7:0]       hist_addr_r;
  logic [CNT_W-1:0] t_total_r;

  logic             in_hs_s, out_hs_s, last_bin_s, prefetch_s;
  logic [CNT_W-1:0] base_s, inc_s;
  logic             rd_en_s, wr_en_s;
  logic [7:0]       rd_addr_s, wr_addr_s;
  logic [CNT_W-1:0] wr_data_s;

  assign in_hs_s    = (state_r == ACCUM) && s_axis_tvalid;
  assign out_hs_s   = (state_r == READ) && hist_valid_r && readout_ready;
  assign last_bin_s = out_hs_s && (hist_addr_r == 8'd255);
  assign prefetch_s = (state_r == DRAIN) && (drain_cnt_r == 2'd2);
  // A write landing on the same edge as the read is invisible to it, so take the in-flight value.
  assign base_s     = (v2_r && (a2_r == a1_r)) ? d2_r : rd_data_r;
  assign inc_s      = sat_inc(base_s);

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      CLEAR: if (clr_idx_r == 8'd255) state_s = ACCUM; else state_s = CLEAR;
      ACCUM: if (in_hs_s && s_axis_tlast) state_s = DRAIN; else state_s = ACCUM;
      DRAIN: if (drain_cnt_r == 2'd2) state_s = READ; else state_s = DRAIN;
      READ: begin
        if (done_r) begin
`ifdef HIST_CLEAR_ON_READ_EN
          state_s = ACCUM;
`else
          state_s = CLEAR;
`endif
        end else begin
          state_s = READ;
        end
      end
      default: state_s = CLEAR;
    endcase
  end

  // RAM port steering: one read port, one write port.
  always_comb begin
    rd_en_s   = 1'b0;
    rd_addr_s = 8'd0;
    wr_en_s   = 1'b0;
    wr_addr_s = 8'd0;
    wr_data_s = {CNT_W{1'b0}};
    if (in_hs_s) begin
      rd_en_s   = 1'b1;
      rd_addr_s = s_axis_tdata;
    end else if (prefetch_s) begin
      rd_en_s   = 1'b1;
      rd_addr_s = 8'd0;
    end else if (out_hs_s) begin
      rd_en_s   = 1'b1;
      rd_addr_s = hist_addr_r + 8'd1;
    end else begin
      rd_en_s   = 1'b0;
    end
    if (state_r == CLEAR) begin
      wr_en_s   = 1'b1;
      wr_addr_s = clr_idx_r;
    end else if (v1_r) begin
      wr_en_s   = 1'b1;
      wr_addr_s = a1_r;
      wr_data_s = inc_s;
    end else if (out_hs_s) begin
`ifdef HIST_CLEAR_ON_READ_EN
      wr_en_s   = 1'b1;
      wr_addr_s = hist_addr_r;
`else
      wr_en_s   = 1'b0;
`endif
    end else begin
      wr_en_s   = 1'b0;
    end
  end

  // Bin storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_r[wr_addr_s] <= wr_data_s;
  end

  // Control, pipeline and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= CLEAR;
      clr_idx_r    <= 8'd0;
      drain_cnt_r  <= 2'd0;
      frame_cnt_r  <= {CNT_W{1'b0}};
      a1_r         <= 8'd0;
      a2_r         <= 8'd0;
      v1_r         <= 1'b0;
      v2_r         <= 1'b0;
      d2_r         <= {CNT_W{1'b0}};
      rd_data_r    <= {CNT_W{1'b0}};
      tready_r     <= 1'b0;
      hist_valid_r <= 1'b0;
      hist_addr_r  <= 8'd0;
      t_total_r    <= {CNT_W{1'b0}};
      done_r       <= 1'b0;
      busy_r       <= 1'b1;
    end else begin
      state_r     <= state_s;
      clr_idx_r   <= (state_r == CLEAR) ? clr_idx_r + 8'd1 : 8'd0;
      drain_cnt_r <= (state_r == DRAIN) ? drain_cnt_r + 2'd1 : 2'd0;
      v1_r        <= in_hs_s;
      if (in_hs_s) a1_r <= s_axis_tdata;
      v2_r        <= v1_r;
      a2_r        <= a1_r;
      d2_r        <= inc_s;
      if (rd_en_s) rd_data_r <= mem_r[rd_addr_s];
      if (in_hs_s) begin
        if (s_axis_tlast) begin
          t_total_r   <= sat_inc(frame_cnt_r);
          frame_cnt_r <= {CNT_W{1'b0}};
        end else begin
          frame_cnt_r <= sat_inc(frame_cnt_r);
        end
      end
      if (prefetch_s) hist_valid_r <= 1'b1;
      else if (last_bin_s) hist_valid_r <= 1'b0;
      if (out_hs_s) hist_addr_r <= hist_addr_r + 8'd1;
      done_r   <= last_bin_s;
      tready_r <= (state_s == ACCUM);
      busy_r   <= (state_s != ACCUM);
    end
  end

  assign s_axis_tready = tready_r;
  assign hist_valid    = hist_valid_r;
  assign hist_addr     = hist_addr_r;
  assign hist_out      = rd_data_r;
  assign t_total       = t_total_r;
  assign readout_done  = done_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_hist_accum.sv
// Bench for hist_accum: frame table with a readout scoreboard, plus reset, latency and saturation sequences.
module tb_hist_accum;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic        readout_ready, hist_valid, readout_done, busy;
  logic [7:0]  hist_addr;
  logic [31:0] hist_out, t_total;

  logic [7:0]  tdata4;
  logic        tvalid4, tlast4, tready4, rr4, hvalid4, done4, busy4;
  logic [7:0]  haddr4;
  logic [3:0]  hout4, ttot4;

  always #5 clk = ~clk;

  hist_accum #(.CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready), .readout_ready(readout_ready),
    .hist_valid(hist_valid), .hist_addr(hist_addr), .hist_out(hist_out), .t_total(t_total),
    .readout_done(readout_done), .busy(busy));

  hist_accum #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .s_axis_tdata(tdata4), .s_axis_tvalid(tvalid4),
    .s_axis_tlast(tlast4), .s_axis_tready(tready4), .readout_ready(rr4),
    .hist_valid(hvalid4), .hist_addr(haddr4), .hist_out(hout4), .t_total(ttot4),
    .readout_done(done4), .busy(busy4));

  typedef struct {
    int len; int mode; int a; int b; int rr_rand; int chk_bin; int exp_bin; int exp_total;
  } vec_t;
  typedef struct {
    logic [7:0] addr; logic [31:0] val; logic [31:0] tot;
  } exp_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb_q[$];
  int unsigned model[256];
  bit          rr_rand_g = 1'b0;
  vec_t        vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset();
    chk("rst_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_valid", 64'(hist_valid), 64'd0);
    chk("rst_addr", 64'(hist_addr), 64'd0);
    chk("rst_out", 64'(hist_out), 64'd0);
    chk("rst_total", 64'(t_total), 64'd0);
    chk("rst_done", 64'(readout_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (s_axis_tready !== 1'b1 && n < 3000) begin step(); n++; end
    chk("tready_wait", 64'(s_axis_tready), 64'd1);
  endtask

  // Drives one frame at full rate and, when it ends with tlast, queues the 256 expected bins.
  task automatic send_frame(input vec_t v, input bit with_last);
    logic [7:0] p;
    int n;
    wait_ready();
    rr_rand_g = (v.rr_rand != 0);
    for (int i = 0; i < v.len; i++) begin
      case (v.mode)
        1: p = ((i % 6) == 0 || (i % 6) == 1 || (i % 6) == 3) ? 8'(v.a) : 8'(v.b);
        2: p = 8'($urandom_range(0, 255));
        3: p = ((i % 2) == 0) ? 8'(v.a) : 8'(v.b);
        default: p = 8'(v.a);
      endcase
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = p;
      s_axis_tlast  = with_last && (i == v.len - 1);
      model[p]++;
      step();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (with_last) begin
      for (int k = 0; k < 256; k++) begin
        exp_t e;
        e.addr = 8'(k);
        e.val  = (k == v.chk_bin) ? 32'(v.exp_bin) : 32'(model[k]);
        e.tot  = 32'(v.exp_total);
        sb_q.push_back(e);
        model[k] = 0;
      end
      n = 0;
      while (hist_valid !== 1'b1 && n < 10) begin step(); n++; end
      chk("tlast_to_valid", 64'(n), 64'd3);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (readout_done !== 1'b1 && n < 4000) begin step(); n++; end
    chk("done_seen", 64'(readout_done), 64'd1);
    n = 0;
    while (s_axis_tready !== 1'b1 && n < 400) begin step(); n++; end
`ifdef HIST_CLEAR_ON_READ_EN
    chk("done_to_ready", 64'(n), 64'd1);
`else
    chk("done_to_ready", 64'(n), 64'd257);
`endif
  endtask

  // Readout monitor: every valid cycle must match the queue head; a handshake pops it.
  initial begin
    exp_t e;
    logic done_pend;
    done_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (readout_done === 1'b1 || done_pend) chk("readout_done", 64'(readout_done), 64'(done_pend));
        done_pend = 1'b0;
        if (hist_valid === 1'b1) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_beat", 64'(hist_valid), 64'd0);
          end else begin
            e = sb_q[0];
            chk("hist_addr", 64'(hist_addr), 64'(e.addr));
            chk("hist_out", 64'(hist_out), 64'(e.val));
            chk("t_total", 64'(t_total), 64'(e.tot));
            if (readout_ready === 1'b1) begin
              void'(sb_q.pop_front());
              done_pend = (e.addr == 8'd255);
            end
          end
        end
      end
    end
  end

  // Readout backpressure source.
  initial begin
    readout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      readout_ready = rr_rand_g ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    vec_t v;
    int   n, beats;
    vecs[0] = '{len: 4,    mode: 0, a: 7,   b: 0, rr_rand: 0, chk_bin: 7,   exp_bin: 4,   exp_total: 4};
    vecs[1] = '{len: 1000, mode: 1, a: 3,   b: 5, rr_rand: 0, chk_bin: 3,   exp_bin: 501, exp_total: 1000};
    vecs[2] = '{len: 300,  mode: 0, a: 200, b: 0, rr_rand: 1, chk_bin: 200, exp_bin: 300, exp_total: 300};
    vecs[3] = '{len: 9,    mode: 3, a: 4,   b: 6, rr_rand: 1, chk_bin: 4,   exp_bin: 5,   exp_total: 9};
    vecs[4] = '{len: 500,  mode: 2, a: 0,   b: 0, rr_rand: 1, chk_bin: -1,  exp_bin: 0,   exp_total: 500};
    vecs[5] = '{len: 1,    mode: 0, a: 42,  b: 0, rr_rand: 0, chk_bin: 42,  exp_bin: 1,   exp_total: 1};
    vecs[6] = '{len: 64,   mode: 0, a: 0,   b: 0, rr_rand: 0, chk_bin: 0,   exp_bin: 64,  exp_total: 64};
    vecs[7] = '{len: 16,   mode: 0, a: 255, b: 0, rr_rand: 0, chk_bin: 255, exp_bin: 16,  exp_total: 16};
    for (int k = 0; k < 256; k++) model[k] = 0;

    reset_n = 1'b0;
    s_axis_tdata = 8'd0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    tdata4 = 8'd0; tvalid4 = 1'b0; tlast4 = 1'b0; rr4 = 1'b1;
    repeat (3) step();
    chk_reset();

    // Pixels offered during CLEAR must be ignored.
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'd77; s_axis_tlast = 1'b1;
    reset_n = 1'b1;
    for (int c = 1; c <= 256; c++) begin
      step();
      if (c == 200) begin s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; end
      if (c == 255) chk("ready_before_257", 64'(s_axis_tready), 64'd0);
      if (c == 256) chk("ready_at_257", 64'(s_axis_tready), 64'd1);
    end

    for (int r = 0; r < 8; r++) begin
      send_frame(vecs[r], 1'b1);
      wait_done();
    end

    // Reset in the middle of a frame abandons it and restarts CLEAR.
    v = '{len: 10, mode: 0, a: 9, b: 0, rr_rand: 0, chk_bin: -1, exp_bin: 0, exp_total: 0};
    send_frame(v, 1'b0);
    for (int k = 0; k < 256; k++) model[k] = 0;
    reset_n = 1'b0;
    #1;
    chk_reset();
    step();
    reset_n = 1'b1;
    v = '{len: 2, mode: 0, a: 1, b: 0, rr_rand: 0, chk_bin: 9, exp_bin: 0, exp_total: 2};
    send_frame(v, 1'b1);
    wait_done();
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    // Saturation on the 4-bit instance.
    n = 0;
    while (tready4 !== 1'b1 && n < 400) begin step(); n++; end
    chk("sat_tready", 64'(tready4), 64'd1);
    for (int i = 0; i < 20; i++) begin
      tvalid4 = 1'b1; tdata4 = 8'd12; tlast4 = (i == 19);
      step();
    end
    tvalid4 = 1'b0; tlast4 = 1'b0;
    beats = 0;
    n = 0;
    while (done4 !== 1'b1 && n < 400) begin
      if (hvalid4 === 1'b1) begin
        chk("sat_addr", 64'(haddr4), 64'(beats));
        chk("sat_bin", 64'(hout4), (beats == 12) ? 64'd15 : 64'd0);
        chk("sat_total", 64'(ttot4), 64'd15);
        beats++;
      end
      step();
      n++;
    end
    chk("sat_beats", 64'(beats), 64'd256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
